decoding_block: RTL
===================

Name: decoding_block

Overview:
Receive-side counterpart of the lane encoder. It accepts one deserialized, encoded symbol per lane from the deserializer:
- Gen3: 132-bit symbol, 4-bit sync header plus 128 data bits.
- Gen2: 66-bit symbol, 2-bit sync header plus 64 data bits.
- Gen4: byte pass-through.

It checks and strips the sync header, classifies each symbol as ordered-set or transport data, and unloads the payload one byte per lane per clock to the lane deskew/receive logic.

Parameters:
- NUM_BYTES_G3, 16, payload bytes per Gen3 symbol.
- NUM_BYTES_G2, 8, payload bytes per Gen2 symbol.

Ports:
- dec_clk  input  1  decoder clock (byte rate)
- rst  input  1  asynchronous reset, active-high
- enable  input  1  block enable; low flushes state
- gen_speed  input  2  0=Gen4 byte mode, 1=Gen3 (132b), 2=Gen2 (66b), 3=reserved
- sym_valid  input  1  one-cycle strobe: new encoded symbol on both lanes
- lane_0_rx_enc  input  132  lane 0 encoded symbol; sync header in LSBs
- lane_1_rx_enc  input  132  lane 1 encoded symbol
- lane_0_rx  output  8  lane 0 decoded byte
- lane_1_rx  output  8  lane 1 decoded byte
- rx_valid  output  1  lane_x_rx valid this cycle
- rx_os  output  1  current byte belongs to an ordered-set symbol (0 = transport)
- sym_start  output  1  pulses with byte 0 of each symbol
- sync_err  output  1  one-cycle pulse: invalid or mismatched sync header, symbol dropped
- ovf_err  output  1  one-cycle pulse: symbol arrived while unloading (not on last byte), new symbol dropped

Behaviour:
Reset and enable:
- rst high (async): all outputs 0, state IDLE, buffers and byte counter 0.
- enable low (sampled on dec_clk): same clearing as reset, applied synchronously.

Header decode:
- Gen3, bits [3:0]: 4'b0101 = ordered set, 4'b1010 = transport.
- Gen2, bits [1:0]: 2'b01 = ordered set, 2'b10 = transport.
- Any other value on either lane, or a valid but different type on the two lanes → sync_err pulses the next cycle, symbol not loaded, state unchanged.

Byte mapping:
- Gen3: byte k = enc[11+8k : 4+8k], k = 0..15.
- Gen2: byte k = enc[9+8k : 2+8k], k = 0..7.
- Byte 0 is emitted first. Lane 1 uses the same mapping.

State machine:
- IDLE → UNLOAD on valid sym_valid. Latch both payloads, the type, and the current gen_speed into a shadow register, and set byte_idx=0.
- UNLOAD: every cycle drive lane_x_rx = byte[byte_idx], rx_valid=1, rx_os=latched type, sym_start=(byte_idx==0), then byte_idx++.
- Last byte is byte_idx = N-1, with N from the latched gen.
- On the last byte: if a valid sym_valid arrives, reload and stay in UNLOAD (gapless back-to-back); otherwise return to IDLE.

Latency and timing rules:
- sym_valid at cycle T → byte 0 registered on outputs at T+1; last byte at T+N.
- gen_speed changes mid-symbol are ignored until the next capture.
- Outputs are registered. rx_valid=0 forces lane_x_rx=0, rx_os=0, sym_start=0.

Gen4 (gen_speed=0):
- No state machine.
- sym_valid at T → lane_x_rx = lane_x_rx_enc[7:0] at T+1, rx_valid=1, sym_start=1, rx_os=0.
- No header check.

gen_speed=3:
- sym_valid is ignored and no output is produced.

Simultaneous events:
- Invalid header on the last byte: finish the last byte, pulse sync_err, go to IDLE.
- sym_valid while UNLOAD and byte_idx < N-1: ovf_err pulses, current unload continues unaffected.
- Reset or enable drop mid-unload: abort immediately, no partial bytes after the clearing edge.

Test Plan:
1. Gen3: sym_valid with lane_0 payload bytes 0x00..0x0F and header 4'b1010 → bytes 0x00..0x0F on cycles T+1..T+16, rx_os=0, sym_start only at T+1.
2. Gen2: header 2'b01, lane_1 bytes 0xA0..0xA7 → 8 bytes with rx_os=1. A second symbol strobed at T+8 → its byte 0 at T+9, no gap, no ovf_err.
3. Gen3: header 4'b0000 on lane 0 → sync_err pulse at T+1, rx_valid stays 0. Lane 0 header 0101 with lane 1 header 1010 → sync_err.
4. Gen3: sym_valid again at T+5 → ovf_err at T+6, original 16 bytes still complete correctly.
5. Gen2: rst asserted asynchronously at byte 3 → all outputs 0 immediately. After release, a fresh symbol decodes from byte 0.
6. Gen4: sym_valid each cycle with lane_0_rx_enc[7:0]=0x3C → lane_0_rx=0x3C one cycle later. gen_speed=3 strobe → no rx_valid.

Source files
------------

// File: rtl/decoding_block_if.sv
// Receive symbol/byte bus between the deserializer and the lane decoder.
//   sym_valid             : one-cycle strobe, new encoded symbol on both lanes
//   lane_0/1_rx_enc[131:0]: encoded symbols, sync header in the LSBs
//   lane_0/1_rx[7:0]      : decoded bytes
//   rx_valid, rx_os, sym_start, sync_err, ovf_err : decoded-byte qualifiers / error pulses
// master = symbol source / byte sink, slave = decoder.
interface decoding_block_if;
   logic         sym_valid;
   logic [131:0] lane_0_rx_enc;
   logic [131:0] lane_1_rx_enc;
   logic [7:0]   lane_0_rx;
   logic [7:0]   lane_1_rx;
   logic         rx_valid;
   logic         rx_os;
   logic         sym_start;
   logic         sync_err;
   logic         ovf_err;

   modport master (
      output sym_valid, lane_0_rx_enc, lane_1_rx_enc,
      input  lane_0_rx, lane_1_rx, rx_valid, rx_os, sym_start, sync_err, ovf_err
   );

   modport slave (
      input  sym_valid, lane_0_rx_enc, lane_1_rx_enc,
      output lane_0_rx, lane_1_rx, rx_valid, rx_os, sym_start, sync_err, ovf_err
   );
endinterface

// File: rtl/decoding_block.sv
// Two-lane receive decoder: checks/strips the sync header of Gen3 (132b) and
// Gen2 (66b) symbols, classifies ordered-set vs transport, and unloads the
// payload one byte per lane per clock. Gen4 is a byte pass-through.
//   dec_clk   : byte-rate clock
//   rst       : asynchronous reset, active-high
//   enable    : low clears all state synchronously
//   gen_speed : 0=Gen4, 1=Gen3, 2=Gen2, 3=reserved (strobes ignored)
//   bus       : symbol input / decoded byte output (decoding_block_if.slave)
module decoding_block #(
   parameter int unsigned NUM_BYTES_G3 = 16,
   parameter int unsigned NUM_BYTES_G2 = 8
) (
   input  logic             dec_clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [1:0]       gen_speed,
   decoding_block_if.slave  bus
);

   typedef enum logic {ST_IDLE, ST_UNLOAD} state_t;

   state_t       r_state;
   logic [127:0] r_buf0;
   logic [127:0] r_buf1;
   logic         r_os_type;
   logic [1:0]   r_gen;
   logic [3:0]   r_idx;       // index of the byte currently on the outputs
   logic [7:0]   r_lane_0_rx;
   logic [7:0]   r_lane_1_rx;
   logic         r_rx_valid;
   logic         r_rx_os;
   logic         r_sym_start;
   logic         r_sync_err;
   logic         r_ovf_err;

   logic         w_hdr_ok;
   logic         w_hdr_os;
   logic [127:0] w_pay0;
   logic [127:0] w_pay1;
   logic [3:0]   w_last_idx;
   logic [3:0]   w_next_idx;

   // Header check and payload extraction for the current gen_speed.
   always_comb begin
      w_hdr_ok = 1'b0;
      w_hdr_os = 1'b0;
      w_pay0   = '0;
      w_pay1   = '0;
      case (gen_speed)
         2'd1: begin
            w_pay0   = bus.lane_0_rx_enc[131:4];
            w_pay1   = bus.lane_1_rx_enc[131:4];
            w_hdr_ok = ((bus.lane_0_rx_enc[3:0] == 4'b0101) || (bus.lane_0_rx_enc[3:0] == 4'b1010))
                       && (bus.lane_0_rx_enc[3:0] == bus.lane_1_rx_enc[3:0]);
            w_hdr_os = (bus.lane_0_rx_enc[3:0] == 4'b0101);
         end
         2'd2: begin
            w_pay0   = {64'd0, bus.lane_0_rx_enc[65:2]};
            w_pay1   = {64'd0, bus.lane_1_rx_enc[65:2]};
            w_hdr_ok = ((bus.lane_0_rx_enc[1:0] == 2'b01) || (bus.lane_0_rx_enc[1:0] == 2'b10))
                       && (bus.lane_0_rx_enc[1:0] == bus.lane_1_rx_enc[1:0]);
            w_hdr_os = (bus.lane_0_rx_enc[1:0] == 2'b01);
         end
         default: ;
      endcase
   end

   always_comb begin
      w_last_idx = (r_gen == 2'd1) ? 4'(NUM_BYTES_G3 - 1) : 4'(NUM_BYTES_G2 - 1);
      w_next_idx = r_idx + 4'd1;
   end

   // Byte 0 is registered straight from the incoming symbol at the capture
   // edge; later bytes come from the latched buffers. A new symbol can be
   // captured whenever no byte remains to emit (IDLE, or last byte shown).
   always_ff @(posedge dec_clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_buf0      <= '0;
         r_buf1      <= '0;
         r_os_type   <= 1'b0;
         r_gen       <= '0;
         r_idx       <= '0;
         r_lane_0_rx <= '0;
         r_lane_1_rx <= '0;
         r_rx_valid  <= 1'b0;
         r_rx_os     <= 1'b0;
         r_sym_start <= 1'b0;
         r_sync_err  <= 1'b0;
         r_ovf_err   <= 1'b0;
      end else if (!enable) begin
         r_state     <= ST_IDLE;
         r_buf0      <= '0;
         r_buf1      <= '0;
         r_os_type   <= 1'b0;
         r_gen       <= '0;
         r_idx       <= '0;
         r_lane_0_rx <= '0;
         r_lane_1_rx <= '0;
         r_rx_valid  <= 1'b0;
         r_rx_os     <= 1'b0;
         r_sym_start <= 1'b0;
         r_sync_err  <= 1'b0;
         r_ovf_err   <= 1'b0;
      end else begin
         r_lane_0_rx <= '0;
         r_lane_1_rx <= '0;
         r_rx_valid  <= 1'b0;
         r_rx_os     <= 1'b0;
         r_sym_start <= 1'b0;
         r_sync_err  <= 1'b0;
         r_ovf_err   <= 1'b0;
         if ((r_state == ST_UNLOAD) && (r_idx != w_last_idx)) begin
            r_lane_0_rx <= r_buf0[{w_next_idx, 3'b000} +: 8];
            r_lane_1_rx <= r_buf1[{w_next_idx, 3'b000} +: 8];
            r_rx_valid  <= 1'b1;
            r_rx_os     <= r_os_type;
            r_idx       <= w_next_idx;
            if (bus.sym_valid && (gen_speed != 2'd3))
               r_ovf_err <= 1'b1;
         end else begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            if (bus.sym_valid) begin
               case (gen_speed)
                  2'd0: begin
                     r_lane_0_rx <= bus.lane_0_rx_enc[7:0];
                     r_lane_1_rx <= bus.lane_1_rx_enc[7:0];
                     r_rx_valid  <= 1'b1;
                     r_sym_start <= 1'b1;
                  end
                  2'd1, 2'd2: begin
                     if (w_hdr_ok) begin
                        r_state     <= ST_UNLOAD;
                        r_buf0      <= w_pay0;
                        r_buf1      <= w_pay1;
                        r_os_type   <= w_hdr_os;
                        r_gen       <= gen_speed;
                        r_lane_0_rx <= w_pay0[7:0];
                        r_lane_1_rx <= w_pay1[7:0];
                        r_rx_valid  <= 1'b1;
                        r_rx_os     <= w_hdr_os;
                        r_sym_start <= 1'b1;
                     end else begin
                        r_sync_err <= 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign bus.lane_0_rx = r_lane_0_rx;
   assign bus.lane_1_rx = r_lane_1_rx;
   assign bus.rx_valid  = r_rx_valid;
   assign bus.rx_os     = r_rx_os;
   assign bus.sym_start = r_sym_start;
   assign bus.sync_err  = r_sync_err;
   assign bus.ovf_err   = r_ovf_err;

endmodule
